alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
Out-of-order issue buffer that sits between rename/dispatch and the ALU. It holds dispatched ALU operations until both source operands are available. Operands are captured from the common data bus (CDB) by ROB tag. Each cycle it issues the oldest fully-ready operation to the ALU, whose result returns on the CDB and marks the matching reorder buffer entry ready.

Parameters:
RS_DEPTH, 4, number of entries (power of two, >= 2)
TAG_BITS, 3, ROB tag width (matches ROB_DEPTH_BITS)
DATA_WIDTH, 32, operand and result width
OP_BITS, 4, ALU control code width
CNT_BITS, $clog2(RS_DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  branch-mispredict flush; clears all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available (occupancy < RS_DEPTH)
disp_op  in  OP_BITS  ALU control
disp_rob_tag  in  TAG_BITS  destination ROB tag
disp_src1_rdy / disp_src2_rdy  in  1  operand already valid at dispatch
disp_src1_val / disp_src2_val  in  DATA_WIDTH  operand value when rdy
disp_src1_tag / disp_src2_tag  in  TAG_BITS  producing ROB tag when not rdy
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_BITS  broadcast ROB tag
cdb_data  in  DATA_WIDTH  broadcast result
iss_valid  out  1  an entry is ready to issue
iss_ready  in  1  ALU accepts this cycle
iss_op  out  OP_BITS  selected op
iss_a / iss_b  out  DATA_WIDTH  selected operands
iss_rob_tag  out  TAG_BITS  selected destination tag
occupancy  out  CNT_BITS  valid entry count

Behaviour:
- Storage is a collapsing queue. Entry 0 is oldest; valid entries occupy indices 0..occupancy-1 contiguously.
- Entry fields: op, rob_tag, and per source {rdy, val, tag}. An entry is issuable when both rdy bits are set.
- Reset or flush: all entries zeroed, occupancy=0.
  - Outputs: disp_ready=1, iss_valid=0, iss_op/iss_a/iss_b/iss_rob_tag=0.
  - flush has priority over dispatch, issue and CDB in the same cycle.
- Dispatch fires when disp_valid & disp_ready.
  - The entry is written at index occupancy, or at occupancy-1 if an issue also fires that cycle.
  - disp_ready depends only on registered occupancy. A full RS deasserts it even if an issue fires that cycle.
- Dispatch bypass: for a source with rdy=0, if cdb_valid and cdb_tag equals that source's tag, store rdy=1 and val=cdb_data.
- Wakeup: every valid entry's not-ready source with a matching tag captures cdb_data and sets rdy=1 at the clock edge.
- Issue select is combinational from registered state: the lowest-index issuable entry.
  - iss_valid=1 iff one exists. Outputs reflect that entry; they are 0 when none exists.
  - Wakeup-to-issue latency is 1 cycle; an operand captured at edge N is issuable in cycle N.
- Issue fires when iss_valid & iss_ready.
  - At the next edge the selected entry is removed and all higher entries shift down one index.
  - Wakeups apply to the shifted entries in the same edge.
- Occupancy update: +1 on dispatch only, -1 on issue only, unchanged on both or neither.
- If iss_valid=1 and iss_ready=0, the selected entry is held. Selection may change next cycle only if an older entry became ready.
- Simultaneous dispatch + issue at occupancy=1 leaves the new entry at index 0.
- A CDB tag matching both sources of one entry sets both.
- Tags are unique among in-flight producers. There is no multiple-match arbitration.

Decomposition:
- mips_core_pkg gets:
  - typedef rs_src_t {rdy, val, tag}
  - typedef rs_entry_t {op, rob_tag, src1, src2}
  - constant RS_DEPTH
- Sub-module rs_select: combinational find-first-issuable over RS_DEPTH ready bits. Outputs are a valid bit and an index.

Test Plan:
- Reset, then dispatch op=ADD tag=2 with src1=5 and src2=7 (both rdy), iss_ready=1 → next cycle iss_valid=1, iss_a=5, iss_b=7, iss_rob_tag=2; following cycle occupancy=0.
- Dispatch tag=1 with src1 waiting on tag 4; cycle later cdb_valid, tag=4, data=0x10 → iss_valid=1 the cycle after, iss_a=0x10.
- Dispatch with src2 waiting on tag 3 while the same cycle carries cdb tag=3, data=9 → entry stored ready; issued next cycle with iss_b=9.
- Fill 4 entries, iss_ready=0 → disp_ready=0, occupancy=4; a fifth dispatch is ignored. Raise iss_ready with entry 0 ready → entry 0 issues, then disp_ready=1.
- Entries 0 (not ready) and 1, 2 (ready), iss_ready=1 → tag of entry 1 issues first, then entry 2. Entry 0 issues after its CDB wakeup.
- Occupancy=3 with all entries ready, assert flush together with disp_valid → next cycle occupancy=0, iss_valid=0, disp_ready=1.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, entry layout and the CDB capture helper for the ALU
// reservation station.
package alu_reservation_station_pkg;

    localparam int RS_DEPTH   = 4;
    localparam int TAG_BITS   = 3;
    localparam int DATA_WIDTH = 32;
    localparam int OP_BITS    = 4;
    localparam int CNT_BITS   = $clog2(RS_DEPTH + 1);
    localparam int IDX_BITS   = $clog2(RS_DEPTH);

    typedef struct packed {
        logic                  rdy;
        logic [DATA_WIDTH-1:0] val;
        logic [TAG_BITS-1:0]   tag;
    } rs_src_t;

    typedef struct packed {
        logic [OP_BITS-1:0]  op;
        logic [TAG_BITS-1:0] rob_tag;
        rs_src_t             src1;
        rs_src_t             src2;
    } rs_entry_t;

    // A waiting source grabs the broadcast value when its producer tag goes by.
    function automatic rs_src_t cdb_capture(rs_src_t s, logic cdb_v,
                                            logic [TAG_BITS-1:0] cdb_t,
                                            logic [DATA_WIDTH-1:0] cdb_d);
        rs_src_t r;
        r = s;
        if (!s.rdy && cdb_v && (cdb_t == s.tag)) begin
            r.rdy = 1'b1;
            r.val = cdb_d;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// master = dispatch/CDB/ALU side, slave = reservation station.
interface alu_reservation_station_if;
    import alu_reservation_station_pkg::*;

    // Handshakes: a transfer happens on a posedge where valid & ready are both
    // high; ready never depends combinationally on the matching valid.
    logic                  flush;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [OP_BITS-1:0]    disp_op;
    logic [TAG_BITS-1:0]   disp_rob_tag;
    logic                  disp_src1_rdy;
    logic                  disp_src2_rdy;
    logic [DATA_WIDTH-1:0] disp_src1_val;
    logic [DATA_WIDTH-1:0] disp_src2_val;
    logic [TAG_BITS-1:0]   disp_src1_tag;
    logic [TAG_BITS-1:0]   disp_src2_tag;
    logic                  cdb_valid;
    logic [TAG_BITS-1:0]   cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [OP_BITS-1:0]    iss_op;
    logic [DATA_WIDTH-1:0] iss_a;
    logic [DATA_WIDTH-1:0] iss_b;
    logic [TAG_BITS-1:0]   iss_rob_tag;
    logic [CNT_BITS-1:0]   occupancy;

    modport master (
        output flush, disp_valid, disp_op, disp_rob_tag,
               disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
               disp_src1_tag, disp_src2_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_a, iss_b, iss_rob_tag, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_op, disp_rob_tag,
               disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
               disp_src1_tag, disp_src2_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_a, iss_b, iss_rob_tag, occupancy
    );

endinterface

// File: rtl/alu_reservation_station_rs_select.sv
// Find-first: lowest index whose request bit is set.
module rs_select
    import alu_reservation_station_pkg::*;
#(
    parameter int N  = RS_DEPTH,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Collapsing-queue ALU reservation station: entry 0 is oldest, the oldest
// entry with both operands ready is offered to the ALU each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    alu_reservation_station_if.slave  rs
);

    rs_entry_t           q     [RS_DEPTH];
    rs_entry_t           sh    [RS_DEPTH];
    rs_entry_t           q_nxt [RS_DEPTH];
    logic [CNT_BITS-1:0] occ;
    logic [CNT_BITS-1:0] occ_nxt;
    logic [CNT_BITS-1:0] wr_idx;
    logic [RS_DEPTH-1:0] rdy_vec;
    logic                sel_found;
    logic [IDX_BITS-1:0] sel_idx;
    logic                fire_disp;
    logic                fire_iss;
    rs_entry_t           new_ent;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            rdy_vec[i] = (CNT_BITS'(i) < occ) && q[i].src1.rdy && q[i].src2.rdy;
        end
    end

    rs_select #(.N(RS_DEPTH), .IW(IDX_BITS)) u_select (
        .req   (rdy_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign rs.disp_ready = (occ < CNT_BITS'(RS_DEPTH));
    assign rs.occupancy  = occ;
    assign fire_disp     = rs.disp_valid & rs.disp_ready;
    assign fire_iss      = sel_found & rs.iss_ready;
    // After a removal the live entries end one slot lower, so that is also
    // where a same-cycle dispatch lands.
    assign wr_idx        = fire_iss ? occ - CNT_BITS'(1) : occ;

    always_comb begin
        rs.iss_valid   = sel_found;
        rs.iss_op      = '0;
        rs.iss_a       = '0;
        rs.iss_b       = '0;
        rs.iss_rob_tag = '0;
        if (sel_found) begin
            rs.iss_op      = q[sel_idx].op;
            rs.iss_a       = q[sel_idx].src1.val;
            rs.iss_b       = q[sel_idx].src2.val;
            rs.iss_rob_tag = q[sel_idx].rob_tag;
        end
    end

    always_comb begin
        new_ent.op      = rs.disp_op;
        new_ent.rob_tag = rs.disp_rob_tag;
        new_ent.src1    = cdb_capture('{rdy: rs.disp_src1_rdy, val: rs.disp_src1_val,
                                        tag: rs.disp_src1_tag},
                                      rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
        new_ent.src2    = cdb_capture('{rdy: rs.disp_src2_rdy, val: rs.disp_src2_val,
                                        tag: rs.disp_src2_tag},
                                      rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH - 1; i++) begin
            sh[i] = (fire_iss && (IDX_BITS'(i) >= sel_idx)) ? q[i+1] : q[i];
        end
        sh[RS_DEPTH-1] = fire_iss ? '0 : q[RS_DEPTH-1];
        for (int i = 0; i < RS_DEPTH; i++) begin
            q_nxt[i] = sh[i];
            if (CNT_BITS'(i) < wr_idx) begin
                q_nxt[i].src1 = cdb_capture(sh[i].src1, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
                q_nxt[i].src2 = cdb_capture(sh[i].src2, rs.cdb_valid, rs.cdb_tag, rs.cdb_data);
            end
            if (fire_disp && (CNT_BITS'(i) == wr_idx)) begin
                q_nxt[i] = new_ent;
            end
        end
    end

    always_comb begin
        case ({fire_disp, fire_iss})
            2'b10:   occ_nxt = occ + CNT_BITS'(1);
            2'b01:   occ_nxt = occ - CNT_BITS'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || rs.flush) begin
            for (int i = 0; i < RS_DEPTH; i++) q[i] <= '0;
            occ <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) q[i] <= q_nxt[i];
            occ <= occ_nxt;
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alu_reservation_station_if rs_if ();

    alu_reservation_station dut (
        .clk (clk),
        .rst (rst),
        .rs  (rs_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  tag;
        logic        r1, r2;
        logic [31:0] v1, v2;
        logic [2:0]  t1, t2;
    } m_ent_t;

    m_ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_ready();
        foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    // Reference model: an age-ordered list; removal deletes from the middle.
    always @(posedge clk) begin
        if (rst || rs_if.flush) begin
            mq.delete();
        end else begin
            int     k;
            bit     can_disp;
            m_ent_t e;
            can_disp = (mq.size() < 4);
            k = first_ready();
            if (k >= 0 && rs_if.iss_ready) mq.delete(k);
            if (rs_if.cdb_valid) begin
                foreach (mq[i]) begin
                    if (!mq[i].r1 && mq[i].t1 == rs_if.cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = rs_if.cdb_data; end
                    if (!mq[i].r2 && mq[i].t2 == rs_if.cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = rs_if.cdb_data; end
                end
            end
            if (rs_if.disp_valid && can_disp) begin
                e.op = rs_if.disp_op;       e.tag = rs_if.disp_rob_tag;
                e.r1 = rs_if.disp_src1_rdy; e.v1 = rs_if.disp_src1_val; e.t1 = rs_if.disp_src1_tag;
                e.r2 = rs_if.disp_src2_rdy; e.v2 = rs_if.disp_src2_val; e.t2 = rs_if.disp_src2_tag;
                if (rs_if.cdb_valid && !e.r1 && e.t1 == rs_if.cdb_tag) begin e.r1 = 1; e.v1 = rs_if.cdb_data; end
                if (rs_if.cdb_valid && !e.r2 && e.t2 == rs_if.cdb_tag) begin e.r2 = 1; e.v2 = rs_if.cdb_data; end
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int k;
            k = first_ready();
            chk("m_occupancy", 32'(rs_if.occupancy), 32'(mq.size()));
            chk("m_disp_ready", 32'(rs_if.disp_ready), 32'(mq.size() < 4));
            chk("m_iss_valid", 32'(rs_if.iss_valid), 32'(k >= 0));
            chk("m_iss_op", 32'(rs_if.iss_op), (k >= 0) ? 32'(mq[k].op) : 32'd0);
            chk("m_iss_a", rs_if.iss_a, (k >= 0) ? mq[k].v1 : 32'd0);
            chk("m_iss_b", rs_if.iss_b, (k >= 0) ? mq[k].v2 : 32'd0);
            chk("m_iss_tag", 32'(rs_if.iss_rob_tag), (k >= 0) ? 32'(mq[k].tag) : 32'd0);
        end
    end

    task automatic idle();
        rs_if.flush = 0; rs_if.disp_valid = 0; rs_if.disp_op = 0; rs_if.disp_rob_tag = 0;
        rs_if.disp_src1_rdy = 0; rs_if.disp_src1_val = 0; rs_if.disp_src1_tag = 0;
        rs_if.disp_src2_rdy = 0; rs_if.disp_src2_val = 0; rs_if.disp_src2_tag = 0;
        rs_if.cdb_valid = 0; rs_if.cdb_tag = 0; rs_if.cdb_data = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [2:0] tag,
                        input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [2:0] t2);
        rs_if.disp_valid = 1; rs_if.disp_op = op; rs_if.disp_rob_tag = tag;
        rs_if.disp_src1_rdy = r1; rs_if.disp_src1_val = v1; rs_if.disp_src1_tag = t1;
        rs_if.disp_src2_rdy = r2; rs_if.disp_src2_val = v2; rs_if.disp_src2_tag = t2;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
        rs_if.cdb_valid = 1; rs_if.cdb_tag = tag; rs_if.cdb_data = data;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rs_if.iss_ready = 0;
        rst = 1;
        @(posedge clk);
        #1 chk_en = 1;
        step();
        rst = 0;
        chk("rst_occ", 32'(rs_if.occupancy), 0);
        chk("rst_disp_ready", 32'(rs_if.disp_ready), 1);
        chk("rst_iss_valid", 32'(rs_if.iss_valid), 0);

        // Both operands ready at dispatch.
        rs_if.iss_ready = 1;
        disp(4'd1, 3'd2, 1, 32'd5, 3'd0, 1, 32'd7, 3'd0);
        step();
        chk("t1_iss_valid", 32'(rs_if.iss_valid), 1);
        chk("t1_iss_a", rs_if.iss_a, 32'd5);
        chk("t1_iss_b", rs_if.iss_b, 32'd7);
        chk("t1_iss_tag", 32'(rs_if.iss_rob_tag), 2);
        step();
        chk("t1_occ", 32'(rs_if.occupancy), 0);

        // src1 woken by a later CDB broadcast.
        disp(4'd2, 3'd1, 0, 32'd0, 3'd4, 1, 32'd3, 3'd0);
        step();
        chk("t2_wait", 32'(rs_if.iss_valid), 0);
        cdb(3'd4, 32'h10);
        step();
        chk("t2_iss_valid", 32'(rs_if.iss_valid), 1);
        chk("t2_iss_a", rs_if.iss_a, 32'h10);
        step();
        chk("t2_occ", 32'(rs_if.occupancy), 0);

        // Dispatch bypass from the CDB in the same cycle.
        disp(4'd3, 3'd5, 1, 32'd1, 3'd0, 0, 32'd0, 3'd3);
        cdb(3'd3, 32'd9);
        step();
        chk("t3_iss_valid", 32'(rs_if.iss_valid), 1);
        chk("t3_iss_b", rs_if.iss_b, 32'd9);
        step();

        // Fill, reject a fifth dispatch, then drain.
        rs_if.iss_ready = 0;
        for (int i = 0; i < 4; i++) begin
            disp(4'(i + 4), 3'(i), 1, 32'(i * 10), 3'd0, 1, 32'(i + 100), 3'd0);
            step();
        end
        chk("t4_full_occ", 32'(rs_if.occupancy), 4);
        chk("t4_full_ready", 32'(rs_if.disp_ready), 0);
        disp(4'd9, 3'd6, 1, 32'd1, 3'd0, 1, 32'd1, 3'd0);
        step();
        chk("t4_reject_occ", 32'(rs_if.occupancy), 4);
        chk("t4_hold_tag", 32'(rs_if.iss_rob_tag), 0);
        rs_if.iss_ready = 1;
        step();
        chk("t4_after_iss_occ", 32'(rs_if.occupancy), 3);
        chk("t4_after_iss_ready", 32'(rs_if.disp_ready), 1);
        chk("t4_next_tag", 32'(rs_if.iss_rob_tag), 1);
        repeat (3) step();
        chk("t4_drained", 32'(rs_if.occupancy), 0);

        // Younger ready entries bypass an older waiting one.
        rs_if.iss_ready = 0;
        disp(4'd1, 3'd4, 0, 32'd0, 3'd7, 1, 32'd1, 3'd0); step();
        disp(4'd2, 3'd5, 1, 32'd11, 3'd0, 1, 32'd2, 3'd0); step();
        disp(4'd3, 3'd6, 1, 32'd22, 3'd0, 1, 32'd3, 3'd0); step();
        chk("t5_first_tag", 32'(rs_if.iss_rob_tag), 5);
        rs_if.iss_ready = 1;
        step();
        chk("t5_second_tag", 32'(rs_if.iss_rob_tag), 6);
        chk("t5_second_a", rs_if.iss_a, 32'd22);
        step();
        chk("t5_blocked", 32'(rs_if.iss_valid), 0);
        chk("t5_blocked_occ", 32'(rs_if.occupancy), 1);
        cdb(3'd7, 32'h33);
        step();
        chk("t5_old_tag", 32'(rs_if.iss_rob_tag), 4);
        chk("t5_old_a", rs_if.iss_a, 32'h33);
        step();

        // Issue + dispatch at occupancy 1: new entry lands at index 0.
        rs_if.iss_ready = 0;
        disp(4'd5, 3'd1, 1, 32'h1, 3'd0, 1, 32'h2, 3'd0); step();
        rs_if.iss_ready = 1;
        disp(4'd6, 3'd2, 1, 32'h44, 3'd0, 1, 32'h45, 3'd0); step();
        chk("t6_occ", 32'(rs_if.occupancy), 1);
        chk("t6_tag", 32'(rs_if.iss_rob_tag), 2);
        chk("t6_a", rs_if.iss_a, 32'h44);
        step();

        // One broadcast wakes both sources of an entry.
        disp(4'd7, 3'd3, 0, 32'd0, 3'd5, 0, 32'd0, 3'd5); step();
        cdb(3'd5, 32'h55); step();
        chk("t7_a", rs_if.iss_a, 32'h55);
        chk("t7_b", rs_if.iss_b, 32'h55);
        step();

        // Flush beats a same-cycle dispatch.
        rs_if.iss_ready = 0;
        for (int i = 0; i < 3; i++) begin
            disp(4'd1, 3'(i), 1, 32'(i), 3'd0, 1, 32'(i), 3'd0);
            step();
        end
        chk("t8_pre_occ", 32'(rs_if.occupancy), 3);
        disp(4'd2, 3'd5, 1, 32'd1, 3'd0, 1, 32'd1, 3'd0);
        rs_if.flush = 1;
        step();
        chk("t8_occ", 32'(rs_if.occupancy), 0);
        chk("t8_iss_valid", 32'(rs_if.iss_valid), 0);
        chk("t8_disp_ready", 32'(rs_if.disp_ready), 1);
        step();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
